exc_commit: RTL and testbench
=============================

# exc_commit

Writeback-side exception/commit arbiter. Merges the instruction retiring from WB (its carried exception, ERTN, TLB-op refetch, IDLE) with pending interrupts from the CSR file, and emits one prioritized single-cycle event per retirement on the CSR file's exception inputs. Also drives the pipeline flush, runs the IDLE wait, and blanks retirement for the cycles the CSR file takes to produce its registered redirect.

## Interface
- BLACKOUT_CYC, 2: cycles after a redirect event during which WB retirement is ignored (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  WB holds an instruction ready to retire
- wb_pc  in  32  PC of WB instruction
- wb_exc  in  1  exception carried from earlier stages
- wb_excode / wb_esubcode / wb_badv  in  6/9/32  carried exception info
- wb_is_ertn / wb_is_refetch / wb_is_idle  in  1 each  instruction class
- ie  in  1  global interrupt enable (CRMD.IE)
- lie / is  in  12/12  local enables and pending bits, same packing as CSR outputs
- is_exc / is_ertn / is_fetch_again / is_idle  out  1 each  CSR event pulses
- excode / esubcode  out  6/9  to CSR
- badvaddr / csr_pc  out  32/32  to CSR
- flush  out  1  kill all stages younger than WB this cycle
- wb_ready  out  1  WB may retire/advance this cycle
- retire  out  1  WB instruction architecturally completed

## Operation
- FSM states RUN, BLANK, WAIT (WAIT only with macro). Reset → RUN, blank_cnt=0, idle_pc=0.
- int_pend = ie & |(lie & is).
- RUN, wb_valid=1, priority (highest first):
  - int_pend: is_exc=1, excode=INT(0x00), esubcode=0, csr_pc=wb_pc, badvaddr=0; instruction not retired.
  - wb_exc: is_exc=1, wb_excode/esubcode/badv passed, csr_pc=wb_pc; not retired.
  - wb_is_ertn: is_ertn=1, retire=1.
  - wb_is_refetch: is_fetch_again=1, csr_pc=wb_pc, retire=1.
  - wb_is_idle: is_idle=1, csr_pc=wb_pc, retire=1, idle_pc←wb_pc, next WAIT.
  - else: retire=1, no event.
- Any of is_exc/is_ertn/is_fetch_again asserts flush the same cycle, loads blank_cnt←BLACKOUT_CYC, next BLANK.
- BLANK: wb_ready=0, no events, no retire; blank_cnt decrements; at 1 → RUN. Interrupts ignored.
- WAIT: wb_ready=0, flush=1 continuously; on int_pend: is_exc=1, excode=INT, csr_pc=idle_pc+4, then BLANK.
- All event outputs are combinational from inputs and state; outputs zero when no event. At most one event pulse per cycle.
- wb_valid=0 in RUN: nothing emitted, interrupts deferred until an instruction reaches WB.

## Timing
- Event/flush: 0-cycle latency from wb_valid.
- CSR redirect (exlike/exaddr) valid 1 cycle after event; BLANK covers it, first new retirement ≥ BLACKOUT_CYC+1 cycles after event.
- Reset values: all outputs 0 except wb_ready=1.
- Reset mid-BLANK/WAIT: next cycle RUN, blank_cnt=0.
- wb_ready=1 only in RUN.
- int_pend rising in same cycle as ERTN/IDLE at WB: interrupt wins, ERTN/IDLE not executed.
- pc+4 wraps modulo 2^32.

## Configuration
- EXC_COMMIT_IDLE_EN defined: WAIT state and idle_pc exist as above.
- Undefined: wb_is_idle treated as normal retire, is_idle tied 0, no WAIT state.

## Structure
- Shared package (cpuDefine): excode constants (INT=0x00 plus existing codes), state enum typedef exc_state_t, BLACKOUT default.
- Single module; no sub-module required (blank counter inline).

## Test plan
- Normal retire: wb_valid=1, no flags → retire=1, no events, flush=0, wb_ready=1.
- Carried exception: wb_exc=1, excode=0x09, badv=0x1234 → is_exc=1, csr_pc=wb_pc, flush=1; wb_ready=0 for 2 cycles; new wb_valid in BLANK ignored.
- Interrupt vs ERTN: ie=1, lie[11]=is[11]=1, wb_is_ertn=1 → is_exc, excode=0, is_ertn=0, retire=0.
- IDLE: wb_is_idle at pc 0x1C000100 → is_idle pulse, WAIT; 10 cycles no int → wb_ready=0, flush=1; set is[2]=lie[2]=ie=1 → is_exc, csr_pc=0x1C000104, then BLANK → RUN.
- Refetch: wb_is_refetch=1 → is_fetch_again=1, retire=1, flush=1, BLANK 2 cycles.
- Reset in BLANK: assert reset cycle after event → RUN, outputs zero, wb_ready=1 next cycle.

Source files
------------

// File: rtl/exc_commit_pkg.sv
// rtl/exc_commit_pkg.sv - exception codes, commit FSM state type and defaults for exc_commit
// EXC_COMMIT_IDLE_EN adds the IDLE wait state to exc_state_t.
package exc_commit_pkg;

  localparam int BLACKOUT_DEFAULT = 2;

  localparam logic [5:0] EXC_INT  = 6'h00;
  localparam logic [5:0] EXC_PIL  = 6'h01;
  localparam logic [5:0] EXC_PIS  = 6'h02;
  localparam logic [5:0] EXC_PIF  = 6'h03;
  localparam logic [5:0] EXC_PME  = 6'h04;
  localparam logic [5:0] EXC_PPI  = 6'h07;
  localparam logic [5:0] EXC_ADE  = 6'h08;
  localparam logic [5:0] EXC_ALE  = 6'h09;
  localparam logic [5:0] EXC_SYS  = 6'h0B;
  localparam logic [5:0] EXC_BRK  = 6'h0C;
  localparam logic [5:0] EXC_INE  = 6'h0D;
  localparam logic [5:0] EXC_IPE  = 6'h0E;
  localparam logic [5:0] EXC_FPD  = 6'h0F;
  localparam logic [5:0] EXC_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    EXC_RUN   = 2'd0,
`ifdef EXC_COMMIT_IDLE_EN
    EXC_BLANK = 2'd1,
    EXC_WAIT  = 2'd2
`else
    EXC_BLANK = 2'd1
`endif
  } exc_state_t;

  // Same packing as the CSR ESTAT.IS / ECFG.LIE outputs.
  function automatic logic int_pending(input logic ie, input logic [11:0] lie,
                                       input logic [11:0] is_bits);
    return ie & (|(lie & is_bits));
  endfunction

endpackage

// File: rtl/exc_commit_if.sv
// rtl/exc_commit_if.sv - WB/CSR side signal bundle of the exception/commit arbiter
interface exc_commit_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_exc;
  logic [5:0]  wb_excode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_badv;
  logic        wb_is_ertn;
  logic        wb_is_refetch;
  logic        wb_is_idle;
  logic        ie;
  logic [11:0] lie;
  logic [11:0] is;

  logic        is_exc;
  logic        is_ertn;
  logic        is_fetch_again;
  logic        is_idle;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr;
  logic [31:0] csr_pc;
  logic        flush;
  logic        wb_ready;
  logic        retire;

  modport master (
    output wb_valid, wb_pc, wb_exc, wb_excode, wb_esubcode, wb_badv,
           wb_is_ertn, wb_is_refetch, wb_is_idle, ie, lie, is,
    input  is_exc, is_ertn, is_fetch_again, is_idle, excode, esubcode,
           badvaddr, csr_pc, flush, wb_ready, retire
  );

  modport slave (
    input  wb_valid, wb_pc, wb_exc, wb_excode, wb_esubcode, wb_badv,
           wb_is_ertn, wb_is_refetch, wb_is_idle, ie, lie, is,
    output is_exc, is_ertn, is_fetch_again, is_idle, excode, esubcode,
           badvaddr, csr_pc, flush, wb_ready, retire
  );
endinterface

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - WB exception/commit arbiter: prioritised CSR event, flush, redirect blackout
// EXC_COMMIT_IDLE_EN enables the IDLE wait state and idle_pc.
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter int BLACKOUT_CYC = BLACKOUT_DEFAULT
) (
  input logic       clk,
  input logic       reset,
  exc_commit_if.slave bus
);

  localparam int CNT_W = (BLACKOUT_CYC < 2) ? 1 : $clog2(BLACKOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLACKOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  exc_state_t       state_q;
  logic [CNT_W-1:0] blank_cnt_q;

  logic        int_pend;
  logic        redirect;
  logic        ev_exc;
  logic        ev_ertn;
  logic        ev_fetch;
  logic        ev_idle;
  logic        wait_flush;
  logic        do_retire;
  logic [5:0]  ev_excode;
  logic [8:0]  ev_esub;
  logic [31:0] ev_badv;
  logic [31:0] ev_pc;

`ifdef EXC_COMMIT_IDLE_EN
  logic [31:0] idle_pc_q;
`else
  logic idle_unused;
  assign idle_unused = bus.wb_is_idle;
`endif

  assign int_pend = int_pending(bus.ie, bus.lie, bus.is);

  always_comb begin
    ev_exc     = 1'b0;
    ev_ertn    = 1'b0;
    ev_fetch   = 1'b0;
    ev_idle    = 1'b0;
    wait_flush = 1'b0;
    do_retire  = 1'b0;
    ev_excode  = '0;
    ev_esub    = '0;
    ev_badv    = '0;
    ev_pc      = '0;
    unique case (state_q)
      EXC_RUN: begin
        // Interrupts are only taken against a real instruction at WB.
        if (bus.wb_valid) begin
          if (int_pend) begin
            ev_exc    = 1'b1;
            ev_excode = EXC_INT;
            ev_pc     = bus.wb_pc;
          end else if (bus.wb_exc) begin
            ev_exc    = 1'b1;
            ev_excode = bus.wb_excode;
            ev_esub   = bus.wb_esubcode;
            ev_badv   = bus.wb_badv;
            ev_pc     = bus.wb_pc;
          end else if (bus.wb_is_ertn) begin
            ev_ertn   = 1'b1;
            do_retire = 1'b1;
          end else if (bus.wb_is_refetch) begin
            ev_fetch  = 1'b1;
            ev_pc     = bus.wb_pc;
            do_retire = 1'b1;
`ifdef EXC_COMMIT_IDLE_EN
          end else if (bus.wb_is_idle) begin
            ev_idle   = 1'b1;
            ev_pc     = bus.wb_pc;
            do_retire = 1'b1;
`endif
          end else begin
            do_retire = 1'b1;
          end
        end
      end
      EXC_BLANK: begin
      end
`ifdef EXC_COMMIT_IDLE_EN
      EXC_WAIT: begin
        wait_flush = 1'b1;
        if (int_pend) begin
          ev_exc    = 1'b1;
          ev_excode = EXC_INT;
          ev_pc     = idle_pc_q + 32'd4;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  assign redirect = ev_exc | ev_ertn | ev_fetch;

  assign bus.is_exc         = ev_exc;
  assign bus.is_ertn        = ev_ertn;
  assign bus.is_fetch_again = ev_fetch;
  assign bus.is_idle        = ev_idle;
  assign bus.excode         = ev_excode;
  assign bus.esubcode       = ev_esub;
  assign bus.badvaddr       = ev_badv;
  assign bus.csr_pc         = ev_pc;
  assign bus.flush          = redirect | wait_flush;
  assign bus.wb_ready       = (state_q == EXC_RUN);
  assign bus.retire         = do_retire;

  // BLANK hides WB while the CSR file registers its redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EXC_RUN;
      blank_cnt_q <= '0;
`ifdef EXC_COMMIT_IDLE_EN
      idle_pc_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        EXC_RUN: begin
          if (redirect) begin
            state_q     <= EXC_BLANK;
            blank_cnt_q <= CNT_LOAD;
`ifdef EXC_COMMIT_IDLE_EN
          end else if (ev_idle) begin
            state_q   <= EXC_WAIT;
            idle_pc_q <= bus.wb_pc;
`endif
          end
        end
        EXC_BLANK: begin
          if (blank_cnt_q <= CNT_ONE) begin
            state_q     <= EXC_RUN;
            blank_cnt_q <= '0;
          end else begin
            blank_cnt_q <= blank_cnt_q - CNT_ONE;
          end
        end
`ifdef EXC_COMMIT_IDLE_EN
        EXC_WAIT: begin
          if (ev_exc) begin
            state_q     <= EXC_BLANK;
            blank_cnt_q <= CNT_LOAD;
          end
        end
`endif
        default: begin
          state_q     <= EXC_RUN;
          blank_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - directed self-checking bench for exc_commit
// IDLE scenarios follow EXC_COMMIT_IDLE_EN.
module tb_exc_commit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  exc_commit_if bus ();

  exc_commit #(.BLACKOUT_CYC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {is_exc, is_ertn, is_fetch_again, is_idle, flush, wb_ready, retire}
  wire [6:0] flags = {bus.is_exc, bus.is_ertn, bus.is_fetch_again, bus.is_idle,
                      bus.flush, bus.wb_ready, bus.retire};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.wb_valid      = 1'b0;
    bus.wb_pc         = 32'h0;
    bus.wb_exc        = 1'b0;
    bus.wb_excode     = 6'h0;
    bus.wb_esubcode   = 9'h0;
    bus.wb_badv       = 32'h0;
    bus.wb_is_ertn    = 1'b0;
    bus.wb_is_refetch = 1'b0;
    bus.wb_is_idle    = 1'b0;
    bus.ie            = 1'b0;
    bus.lie           = 12'h0;
    bus.is            = 12'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++;
      $display("FAIL reset_flags: got %b expected %b", flags, 7'b0000010);
    end
    checks++;
    if ({bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc} !== 79'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc});
    end
  endtask

  task automatic test_normal();
    tick();
    clear_inputs();
    bus.wb_valid = 1'b1;
    bus.wb_pc    = 32'h1C00_0000;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL normal_retire: got %b expected %b", flags, 7'b0000011);
    end
    checks++;
    if (bus.csr_pc !== 32'h0) begin
      failures++;
      $display("FAIL normal_csr_pc: got %h expected %h", bus.csr_pc, 32'h0);
    end
    tick();
    bus.wb_valid = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++;
      $display("FAIL idle_bus: got %b expected %b", flags, 7'b0000010);
    end
  endtask

  task automatic test_exception();
    tick();
    clear_inputs();
    bus.wb_valid    = 1'b1;
    bus.wb_pc       = 32'h1C00_0010;
    bus.wb_exc      = 1'b1;
    bus.wb_excode   = 6'h09;
    bus.wb_esubcode = 9'h005;
    bus.wb_badv     = 32'h0000_1234;
    bus.wb_is_ertn  = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b1000110) begin
      failures++;
      $display("FAIL exc_flags: got %b expected %b", flags, 7'b1000110);
    end
    checks++;
    if ({bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc} !==
        {6'h09, 9'h005, 32'h0000_1234, 32'h1C00_0010}) begin
      failures++;
      $display("FAIL exc_data: got %h/%h/%h/%h expected 09/005/00001234/1c000010",
               bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      clear_inputs();
      bus.wb_valid = 1'b1;
      bus.wb_pc    = 32'h1C00_0014;
      bus.wb_exc   = (i == 0);
      #2;
      checks++;
      if (flags !== 7'b0000000) begin
        failures++;
        $display("FAIL exc_blank%0d: got %b expected %b", i, flags, 7'b0000000);
      end
    end
    tick();
    bus.wb_exc = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL exc_resume: got %b expected %b", flags, 7'b0000011);
    end
  endtask

  task automatic test_int_priority();
    tick();
    clear_inputs();
    bus.ie    = 1'b1;
    bus.lie   = 12'h800;
    bus.is    = 12'h800;
    #2;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++;
      $display("FAIL int_deferred: got %b expected %b", flags, 7'b0000010);
    end
    tick();
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = 32'h1C00_0020;
    bus.wb_is_ertn = 1'b1;
    bus.wb_exc     = 1'b1;
    bus.wb_excode  = 6'h09;
    bus.wb_badv    = 32'h0000_DEAD;
    #2;
    checks++;
    if (flags !== 7'b1000110) begin
      failures++;
      $display("FAIL int_flags: got %b expected %b", flags, 7'b1000110);
    end
    checks++;
    if ({bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc} !==
        {6'h00, 9'h000, 32'h0, 32'h1C00_0020}) begin
      failures++;
      $display("FAIL int_data: got %h/%h/%h/%h expected 00/000/00000000/1c000020",
               bus.excode, bus.esubcode, bus.badvaddr, bus.csr_pc);
    end
    tick();
    checks++;
    if (flags !== 7'b0000000) begin
      failures++;
      $display("FAIL int_blank_ignored: got %b expected %b", flags, 7'b0000000);
    end
    tick();
    clear_inputs();
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_pc    = 32'h1C00_0024;
    bus.ie       = 1'b0;
    bus.lie      = 12'h800;
    bus.is       = 12'h800;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL int_masked_ie: got %b expected %b", flags, 7'b0000011);
    end
    tick();
    bus.ie  = 1'b1;
    bus.lie = 12'h008;
    bus.is  = 12'h010;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL int_masked_lie: got %b expected %b", flags, 7'b0000011);
    end
  endtask

  task automatic test_ertn();
    tick();
    clear_inputs();
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = 32'h1C00_0040;
    bus.wb_is_ertn = 1'b1;
    bus.wb_is_refetch = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0100111) begin
      failures++;
      $display("FAIL ertn_flags: got %b expected %b", flags, 7'b0100111);
    end
    tick();
    clear_inputs();
    tick();
    tick();
    bus.wb_valid = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL ertn_resume: got %b expected %b", flags, 7'b0000011);
    end
  endtask

  task automatic test_refetch();
    tick();
    clear_inputs();
    bus.wb_valid      = 1'b1;
    bus.wb_pc         = 32'h1C00_0030;
    bus.wb_is_refetch = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0010111) begin
      failures++;
      $display("FAIL refetch_flags: got %b expected %b", flags, 7'b0010111);
    end
    checks++;
    if (bus.csr_pc !== 32'h1C00_0030) begin
      failures++;
      $display("FAIL refetch_pc: got %h expected %h", bus.csr_pc, 32'h1C00_0030);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      #0;
      checks++;
      if (flags !== 7'b0000000) begin
        failures++;
        $display("FAIL refetch_blank%0d: got %b expected %b", i, flags, 7'b0000000);
      end
    end
    tick();
    bus.wb_is_refetch = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL refetch_resume: got %b expected %b", flags, 7'b0000011);
    end
  endtask

  task automatic test_idle();
`ifdef EXC_COMMIT_IDLE_EN
    tick();
    clear_inputs();
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = 32'h1C00_0100;
    bus.wb_is_idle = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0001011) begin
      failures++;
      $display("FAIL idle_flags: got %b expected %b", flags, 7'b0001011);
    end
    tick();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++;
      if (flags !== 7'b0000100) begin
        failures++;
        $display("FAIL idle_wait%0d: got %b expected %b", i, flags, 7'b0000100);
      end
      tick();
    end
    bus.ie  = 1'b1;
    bus.lie = 12'h004;
    bus.is  = 12'h004;
    #2;
    checks++;
    if (flags !== 7'b1000100 || bus.csr_pc !== 32'h1C00_0104 || bus.excode !== 6'h00) begin
      failures++;
      $display("FAIL idle_wake: got %b pc %h code %h expected 1000100 pc 1c000104 code 00",
               flags, bus.csr_pc, bus.excode);
    end
    tick();
    clear_inputs();
    tick();
    #2;
    checks++;
    if (flags !== 7'b0000000) begin
      failures++;
      $display("FAIL idle_blank: got %b expected %b", flags, 7'b0000000);
    end
    tick();
    checks++;
    if (flags !== 7'b0000010) begin
      failures++;
      $display("FAIL idle_resume: got %b expected %b", flags, 7'b0000010);
    end
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = 32'hFFFF_FFFC;
    bus.wb_is_idle = 1'b1;
    tick();
    clear_inputs();
    bus.ie  = 1'b1;
    bus.lie = 12'h001;
    bus.is  = 12'h001;
    #2;
    checks++;
    if (bus.is_exc !== 1'b1 || bus.csr_pc !== 32'h0) begin
      failures++;
      $display("FAIL idle_wrap: got exc %b pc %h expected exc 1 pc 00000000",
               bus.is_exc, bus.csr_pc);
    end
    tick();
    clear_inputs();
    tick();
    tick();
`else
    tick();
    clear_inputs();
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = 32'h1C00_0100;
    bus.wb_is_idle = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL idle_off_flags: got %b expected %b", flags, 7'b0000011);
    end
    tick();
    bus.wb_is_idle = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL idle_off_next: got %b expected %b", flags, 7'b0000011);
    end
`endif
  endtask

  task automatic test_reset_in_blank();
    tick();
    clear_inputs();
    bus.wb_valid      = 1'b1;
    bus.wb_pc         = 32'h1C00_0200;
    bus.wb_is_refetch = 1'b1;
    #2;
    checks++;
    if (flags !== 7'b0010111) begin
      failures++;
      $display("FAIL rst_blank_event: got %b expected %b", flags, 7'b0010111);
    end
    tick();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    checks++;
    if (flags !== 7'b0000010) begin
      failures++;
      $display("FAIL rst_blank_state: got %b expected %b", flags, 7'b0000010);
    end
    bus.wb_valid = 1'b1;
    bus.wb_pc    = 32'h1C00_0204;
    #1;
    checks++;
    if (flags !== 7'b0000011) begin
      failures++;
      $display("FAIL rst_blank_retire: got %b expected %b", flags, 7'b0000011);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_normal();
    test_exception();
    test_int_priority();
    test_ertn();
    test_refetch();
    test_idle();
    test_reset_in_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
